// File: rtl/pdp_nan_pkg.sv
// pdp_nan_pkg: shared constants, FSM state type and helper functions for the
// PDP NaN/Inf input pre-processor.
//   - FP16 field positions (exponent / mantissa)
//   - input-format code for FP16
//   - helpers locating the cube-end / surface-end bits inside the info field
//   - gate FSM state enum
//   - saturating 32-bit adder used by the NaN/Inf counters
package pdp_nan_pkg;

  localparam int EXP_MSB = 14;
  localparam int EXP_LSB = 10;
  localparam int MAN_MSB = 9;

  localparam logic [1:0] FMT_FP16 = 2'h2;

  // Layer-end markers sit at fixed offsets below the top of the info field.
  localparam int CUBE_END_OFS = 1;
  localparam int SURF_END_OFS = 5;

  function automatic int cube_end_idx(input int info_w);
    return info_w - CUBE_END_OFS;
  endfunction

  function automatic int surf_end_idx(input int info_w);
    return info_w - SURF_END_OFS;
  endfunction

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } gate_state_e;

  // Saturating add: any carry out of bit 31 clamps the result to all-ones.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/pdp_nan_elem_chk.sv
// pdp_nan_elem_chk: purely combinational classifier for one element.
// Ports:
//   elem_i        element bits
//   fp16_en_i     classification enable (input format is FP16)
//   nan_to_zero_i replace NaN elements with zero
//   nan_o, inf_o  element is NaN / +-Inf (0 when classification disabled)
//   elem_o        element after optional NaN flush
module pdp_nan_elem_chk
  import pdp_nan_pkg::*;
#(
  parameter int BWPE = 16
) (
  input  logic [BWPE-1:0] elem_i,
  input  logic            fp16_en_i,
  input  logic            nan_to_zero_i,
  output logic            nan_o,
  output logic            inf_o,
  output logic [BWPE-1:0] elem_o
);

  generate
    if (BWPE == 16) begin : g_fp16
      logic exp_ones_s;
      logic man_zero_s;

      assign exp_ones_s = &elem_i[EXP_MSB:EXP_LSB];
      assign man_zero_s = ~|elem_i[MAN_MSB:0];
      assign nan_o      = fp16_en_i & exp_ones_s & ~man_zero_s;
      assign inf_o      = fp16_en_i & exp_ones_s &  man_zero_s;
      assign elem_o     = (nan_o & nan_to_zero_i) ? {BWPE{1'b0}} : elem_i;
    end else begin : g_passthru
      // Element width cannot be FP16: no classification, data untouched.
      logic unused_ctrl_s;

      assign unused_ctrl_s = fp16_en_i ^ nan_to_zero_i;
      assign nan_o         = 1'b0;
      assign inf_o         = 1'b0;
      assign elem_o        = elem_i;
    end
  endgenerate

endmodule

// File: rtl/pdp_nan_preproc.sv
// pdp_nan_preproc: PDP input pre-processor between PDP RDMA and the PDP core.
// Gates RDMA beats on layer enable (off-fly only), classifies FP16 elements as
// NaN/Inf, optionally flushes NaNs to zero and registers the beat in a
// one-deep output stage with full-throughput valid/ready handshake.
// Optional feature macro: NVDLA_PDP_NAN_CNT_EN -- when defined, per-layer
// NaN/Inf counts are kept in ping-pong slots and published on dp2reg_done;
// when undefined the count outputs are tied to zero.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn   clock, async active-low reset
//   pdp_rdma2dp_valid/ready/pd         input beat (data DW bits + info INFO_W bits)
//   nan_preproc_pvld/prdy/pd           output beat
//   reg2dp_op_en, reg2dp_flying_mode, reg2dp_input_data, reg2dp_nan_to_zero
//   dp2reg_done                        layer-done pulse
//   dp2reg_nan_input_num / dp2reg_inf_input_num  published per-layer counts
module pdp_nan_preproc
  import pdp_nan_pkg::*;
#(
  parameter int BWPE       = 16,
  parameter int THROUGHPUT = 4,
  parameter int INFO_W     = 12
) (
  input  logic                             nvdla_core_clk,
  input  logic                             nvdla_core_rstn,
  input  logic                             pdp_rdma2dp_valid,
  output logic                             pdp_rdma2dp_ready,
  input  logic [BWPE*THROUGHPUT+INFO_W-1:0] pdp_rdma2dp_pd,
  output logic                             nan_preproc_pvld,
  input  logic                             nan_preproc_prdy,
  output logic [BWPE*THROUGHPUT+INFO_W-1:0] nan_preproc_pd,
  input  logic                             reg2dp_op_en,
  input  logic                             reg2dp_flying_mode,
  input  logic [1:0]                       reg2dp_input_data,
  input  logic                             reg2dp_nan_to_zero,
  input  logic                             dp2reg_done,
  output logic [31:0]                      dp2reg_nan_input_num,
  output logic [31:0]                      dp2reg_inf_input_num
);

  localparam int DW       = BWPE * THROUGHPUT;
  localparam int PW       = DW + INFO_W;
  localparam int CUBE_END = cube_end_idx(INFO_W);
  localparam int SURF_END = surf_end_idx(INFO_W);

  gate_state_e           state_q, state_d;
  logic                  op_en_d1_q;
  logic                  out_vld_q, out_vld_d;
  logic [PW-1:0]         out_pd_q, out_pd_d;

  logic                  op_en_rise_s;
  logic                  fp16_en_s;
  logic                  rdy_s;
  logic                  load_s;
  logic                  layer_end_s;
  logic [INFO_W-1:0]     info_s;
  logic [DW-1:0]         flushed_s;
  logic [THROUGHPUT-1:0] nan_flag_s;
  logic [THROUGHPUT-1:0] inf_flag_s;

  assign op_en_rise_s = reg2dp_op_en & ~op_en_d1_q;
  assign fp16_en_s    = (reg2dp_input_data == FMT_FP16) && (BWPE == 16);
  assign info_s       = pdp_rdma2dp_pd[PW-1:DW];
  assign layer_end_s  = info_s[CUBE_END] & info_s[SURF_END];
  assign rdy_s        = (~out_vld_q | nan_preproc_prdy) & (state_q == ST_RUN);
  assign load_s       = pdp_rdma2dp_valid & rdy_s;

  assign pdp_rdma2dp_ready = rdy_s;
  assign nan_preproc_pvld  = out_vld_q;
  assign nan_preproc_pd    = out_pd_q;

  genvar gi;
  generate
    for (gi = 0; gi < THROUGHPUT; gi++) begin : g_elem
      pdp_nan_elem_chk #(
        .BWPE (BWPE)
      ) u_chk (
        .elem_i        (pdp_rdma2dp_pd[gi*BWPE +: BWPE]),
        .fp16_en_i     (fp16_en_s),
        .nan_to_zero_i (reg2dp_nan_to_zero),
        .nan_o         (nan_flag_s[gi]),
        .inf_o         (inf_flag_s[gi]),
        .elem_o        (flushed_s[gi*BWPE +: BWPE])
      );
    end
  endgenerate

  // Gate FSM next state; a layer-end accept in RUN dominates any op_en edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (op_en_rise_s && reg2dp_flying_mode) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RUN: begin
        if (load_s && layer_end_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Output stage next state: hold on stall, capture on load, drop on drain.
  always_comb begin
    out_vld_d = out_vld_q;
    out_pd_d  = out_pd_q;
    if (load_s) begin
      out_vld_d = 1'b1;
      out_pd_d  = {info_s, flushed_s};
    end else if (nan_preproc_prdy) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // Gate FSM, op_en edge detector and output stage registers.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= ST_WAIT;
      op_en_d1_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_pd_q   <= {PW{1'b0}};
    end else begin
      state_q    <= state_d;
      op_en_d1_q <= reg2dp_op_en;
      out_vld_q  <= out_vld_d;
      out_pd_q   <= out_pd_d;
    end
  end

`ifdef NVDLA_PDP_NAN_CNT_EN
  logic [31:0] nan_inc_s, inf_inc_s;
  logic [31:0] nan_sum_s, inf_sum_s;
  logic [31:0] nan_cnt_q, nan_cnt_d;
  logic [31:0] inf_cnt_q, inf_cnt_d;
  logic [31:0] nan_slot_q [2];
  logic [31:0] inf_slot_q [2];
  logic        layer_flag_q;
  logic        wdma_flag_q;
  logic [31:0] nan_num_q, inf_num_q;

  // Popcount of this beat's NaN / Inf flags.
  always_comb begin
    nan_inc_s = 32'd0;
    inf_inc_s = 32'd0;
    for (int i = 0; i < THROUGHPUT; i++) begin
      nan_inc_s = nan_inc_s + {31'd0, nan_flag_s[i]};
      inf_inc_s = inf_inc_s + {31'd0, inf_flag_s[i]};
    end
  end

  assign nan_sum_s = sat_add32(nan_cnt_q, nan_inc_s);
  assign inf_sum_s = sat_add32(inf_cnt_q, inf_inc_s);

  // Running counters accumulate per load and restart after a layer-end beat.
  always_comb begin
    nan_cnt_d = nan_cnt_q;
    inf_cnt_d = inf_cnt_q;
    if (load_s) begin
      if (layer_end_s) begin
        nan_cnt_d = 32'd0;
        inf_cnt_d = 32'd0;
      end else begin
        nan_cnt_d = nan_sum_s;
        inf_cnt_d = inf_sum_s;
      end
    end else begin
      nan_cnt_d = nan_cnt_q;
      inf_cnt_d = inf_cnt_q;
    end
  end

  // Running counts, ping-pong slots and published registers; done reads
  // the pre-write slot value when it coincides with a layer-end write.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      nan_cnt_q     <= 32'd0;
      inf_cnt_q     <= 32'd0;
      nan_slot_q[0] <= 32'd0;
      nan_slot_q[1] <= 32'd0;
      inf_slot_q[0] <= 32'd0;
      inf_slot_q[1] <= 32'd0;
      layer_flag_q  <= 1'b0;
      wdma_flag_q   <= 1'b0;
      nan_num_q     <= 32'd0;
      inf_num_q     <= 32'd0;
    end else begin
      nan_cnt_q <= nan_cnt_d;
      inf_cnt_q <= inf_cnt_d;
      if (load_s && layer_end_s) begin
        nan_slot_q[layer_flag_q] <= nan_sum_s;
        inf_slot_q[layer_flag_q] <= inf_sum_s;
        layer_flag_q             <= ~layer_flag_q;
      end
      if (dp2reg_done) begin
        nan_num_q   <= nan_slot_q[wdma_flag_q];
        inf_num_q   <= inf_slot_q[wdma_flag_q];
        wdma_flag_q <= ~wdma_flag_q;
      end
    end
  end

  assign dp2reg_nan_input_num = nan_num_q;
  assign dp2reg_inf_input_num = inf_num_q;
`else
  // Counting removed: flags and done pulse have no consumer.
  logic unused_cnt_s;

  assign unused_cnt_s         = dp2reg_done ^ (^nan_flag_s) ^ (^inf_flag_s);
  assign dp2reg_nan_input_num = 32'h0;
  assign dp2reg_inf_input_num = 32'h0;
`endif

endmodule

// File: tb/tb_pdp_nan_preproc.sv
module tb_pdp_nan_preproc;

  localparam int DW = 64;
  localparam int IW = 12;
  localparam int PW = DW + IW;
`ifdef NVDLA_PDP_NAN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid;
  logic          ready;
  logic [PW-1:0] in_pd;
  logic          pvld;
  logic          prdy;
  logic [PW-1:0] out_pd;
  logic          op_en;
  logic          flying;
  logic [1:0]    in_fmt;
  logic          n2z;
  logic          done;
  logic [31:0]   nan_num;
  logic [31:0]   inf_num;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pdp_nan_preproc #(
    .BWPE       (16),
    .THROUGHPUT (4),
    .INFO_W     (IW)
  ) dut (
    .nvdla_core_clk       (clk),
    .nvdla_core_rstn      (rstn),
    .pdp_rdma2dp_valid    (valid),
    .pdp_rdma2dp_ready    (ready),
    .pdp_rdma2dp_pd       (in_pd),
    .nan_preproc_pvld     (pvld),
    .nan_preproc_prdy     (prdy),
    .nan_preproc_pd       (out_pd),
    .reg2dp_op_en         (op_en),
    .reg2dp_flying_mode   (flying),
    .reg2dp_input_data    (in_fmt),
    .reg2dp_nan_to_zero   (n2z),
    .dp2reg_done          (done),
    .dp2reg_nan_input_num (nan_num),
    .dp2reg_inf_input_num (inf_num)
  );

  task automatic do_reset;
    rstn   = 1'b0;
    valid  = 1'b0;
    in_pd  = '0;
    op_en  = 1'b0;
    done   = 1'b0;
    prdy   = 1'b1;
    flying = 1'b1;
    in_fmt = 2'h2;
    n2z    = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic arm;
    op_en = 1'b0;
    @(negedge clk);
    op_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_done;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  // Present a beat and wait (bounded) for it to be accepted.
  task automatic send(input logic [PW-1:0] beat);
    int waited;
    valid  = 1'b1;
    in_pd  = beat;
    waited = 0;
    while (!ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total_cnt++;
    if (!ready) $display("FAIL send_timeout: ready=%0b after %0d cycles, required 1", ready, waited);
    else pass_cnt++;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; valid = 1'b0; op_en = 1'b0; done = 1'b0; prdy = 1'b1;
    flying = 1'b1; in_fmt = 2'h2; n2z = 1'b0; in_pd = '0;
    #3;
    total_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else pass_cnt++;
    total_cnt++; if (pvld !== 1'b0) $display("FAIL rst_pvld: got %b want 0", pvld); else pass_cnt++;
    total_cnt++; if (out_pd !== '0) $display("FAIL rst_pd: got %h want 0", out_pd); else pass_cnt++;
    total_cnt++; if (nan_num !== 32'd0) $display("FAIL rst_nan: got %h want 0", nan_num); else pass_cnt++;
    total_cnt++; if (inf_num !== 32'd0) $display("FAIL rst_inf: got %h want 0", inf_num); else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gating;
    logic [PW-1:0] beats [4];
    beats[0] = {12'h001, 64'h0001_0002_0003_0004};
    beats[1] = {12'h002, 64'h1111_2222_3333_4444};
    beats[2] = {12'h880, 64'h5555_6666_3C00_0000};
    beats[3] = {12'h003, 64'h0123_4567_089A_0BCD};
    do_reset;
    flying = 1'b0;
    arm;
    total_cnt++; if (ready !== 1'b0) $display("FAIL onfly_ready: got %b want 0", ready); else pass_cnt++;
    flying = 1'b1;
    arm;
    total_cnt++; if (ready !== 1'b1) $display("FAIL arm_ready: got %b want 1", ready); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      send(beats[k]);
      total_cnt++;
      if (pvld !== 1'b1 || out_pd !== beats[k])
        $display("FAIL gate_beat%0d: pvld=%b pd=%h want 1 %h", k, pvld, out_pd, beats[k]);
      else pass_cnt++;
    end
    total_cnt++; if (ready !== 1'b0) $display("FAIL ready_drop: got %b want 0", ready); else pass_cnt++;
    valid = 1'b1;
    in_pd = beats[3];
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ready !== 1'b0 || pvld !== 1'b0)
      $display("FAIL beat4_stall: ready=%b pvld=%b want 0 0", ready, pvld);
    else pass_cnt++;
    arm;
    total_cnt++; if (ready !== 1'b1) $display("FAIL rearm_ready: got %b want 1", ready); else pass_cnt++;
    @(negedge clk);
    valid = 1'b0;
    total_cnt++;
    if (pvld !== 1'b1 || out_pd !== beats[3])
      $display("FAIL beat4_out: pvld=%b pd=%h want 1 %h", pvld, out_pd, beats[3]);
    else pass_cnt++;
  endtask

  task automatic test_flush;
    do_reset;
    arm;
    n2z = 1'b1;
    send({12'h123, 64'h3C00_FC00_7C00_7C01});
    total_cnt++;
    if (out_pd !== {12'h123, 64'h3C00_FC00_7C00_0000})
      $display("FAIL flush_on: got %h want %h", out_pd, {12'h123, 64'h3C00_FC00_7C00_0000});
    else pass_cnt++;
    n2z = 1'b0;
    send({12'h123, 64'h3C00_FC00_7C00_7C01});
    total_cnt++;
    if (out_pd !== {12'h123, 64'h3C00_FC00_7C00_7C01})
      $display("FAIL flush_off: got %h want %h", out_pd, {12'h123, 64'h3C00_FC00_7C00_7C01});
    else pass_cnt++;
    n2z = 1'b1;
    send({12'h045, 64'hFFFF_7E00_0001_7C00});
    total_cnt++;
    if (out_pd !== {12'h045, 64'h0000_0000_0001_7C00})
      $display("FAIL flush_mix: got %h want %h", out_pd, {12'h045, 64'h0000_0000_0001_7C00});
    else pass_cnt++;
  endtask

  task automatic test_non_fp16;
    do_reset;
    arm;
    in_fmt = 2'h0;
    n2z    = 1'b1;
    send({12'h880, 64'h7C01_7C01_7C01_7C01});
    total_cnt++;
    if (out_pd !== {12'h880, 64'h7C01_7C01_7C01_7C01})
      $display("FAIL nonfp16_data: got %h want %h", out_pd, {12'h880, 64'h7C01_7C01_7C01_7C01});
    else pass_cnt++;
    pulse_done;
    total_cnt++;
    if (nan_num !== 32'd0 || inf_num !== 32'd0)
      $display("FAIL nonfp16_cnt: nan=%0d inf=%0d want 0 0", nan_num, inf_num);
    else pass_cnt++;
    in_fmt = 2'h2;
    n2z    = 1'b0;
  endtask

  task automatic test_counts;
    logic [31:0] exp_a_nan, exp_a_inf, exp_b_nan;
    exp_a_nan = CNT_EN ? 32'd5 : 32'd0;
    exp_a_inf = CNT_EN ? 32'd2 : 32'd0;
    exp_b_nan = CNT_EN ? 32'd1 : 32'd0;
    do_reset;
    arm;
    send({12'h001, 64'h3C00_7C00_7C02_7C01});
    send({12'h002, 64'h0000_FC00_7C10_FE00});
    send({12'h880, 64'h0000_0000_0000_7FFF});
    total_cnt++;
    if (nan_num !== 32'd0) $display("FAIL cnt_pre_done: nan=%0d want 0", nan_num); else pass_cnt++;
    arm;
    send({12'h880, 64'h0000_0000_3C00_7C01});
    pulse_done;
    total_cnt++;
    if (nan_num !== exp_a_nan || inf_num !== exp_a_inf)
      $display("FAIL cnt_layer_a: nan=%0d inf=%0d want %0d %0d", nan_num, inf_num, exp_a_nan, exp_a_inf);
    else pass_cnt++;
    pulse_done;
    total_cnt++;
    if (nan_num !== exp_b_nan || inf_num !== 32'd0)
      $display("FAIL cnt_layer_b: nan=%0d inf=%0d want %0d 0", nan_num, inf_num, exp_b_nan);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] b1, b2;
    b1 = {12'h00A, 64'hAAAA_BBBB_CCCC_DDDD};
    b2 = {12'h00B, 64'h1234_5678_9ABC_0DEF};
    do_reset;
    arm;
    prdy = 1'b0;
    send(b1);
    valid = 1'b1;
    in_pd = b2;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (pvld !== 1'b1 || out_pd !== b1 || ready !== 1'b0)
        $display("FAIL stall_%0d: pvld=%b pd=%h ready=%b want 1 %h 0", i, pvld, out_pd, ready, b1);
      else pass_cnt++;
      @(negedge clk);
    end
    prdy = 1'b1;
    #1;
    total_cnt++; if (ready !== 1'b1) $display("FAIL release_ready: got %b want 1", ready); else pass_cnt++;
    @(negedge clk);
    valid = 1'b0;
    total_cnt++;
    if (pvld !== 1'b1 || out_pd !== b2)
      $display("FAIL release_b2: pvld=%b pd=%h want 1 %h", pvld, out_pd, b2);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (pvld !== 1'b0) $display("FAIL drain_pvld: got %b want 0", pvld); else pass_cnt++;
  endtask

`ifdef NVDLA_PDP_NAN_CNT_EN
  task automatic test_saturation;
    do_reset;
    arm;
    valid = 1'b1;
    in_pd = {12'h880, 64'h7C01_7C01_7C01_7C01};
    force dut.nan_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.nan_cnt_q;
    valid = 1'b0;
    @(negedge clk);
    pulse_done;
    total_cnt++;
    if (nan_num !== 32'hFFFF_FFFF || inf_num !== 32'd0)
      $display("FAIL saturate: nan=%h inf=%h want ffffffff 0", nan_num, inf_num);
    else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid;
    do_reset;
    arm;
    prdy = 1'b0;
    send({12'h001, 64'h7C01_7C01_7C01_7C01});
    total_cnt++; if (pvld !== 1'b1) $display("FAIL mid_held: got %b want 1", pvld); else pass_cnt++;
    #2;
    rstn  = 1'b0;
    op_en = 1'b0;
    #1;
    total_cnt++;
    if (pvld !== 1'b0 || ready !== 1'b0 || out_pd !== '0)
      $display("FAIL mid_rst: pvld=%b ready=%b pd=%h want 0 0 0", pvld, ready, out_pd);
    else pass_cnt++;
    @(negedge clk);
    rstn  = 1'b1;
    prdy  = 1'b1;
    valid = 1'b1;
    in_pd = {12'h880, 64'h3C00_3C00_3C00_3C00};
    repeat (2) @(negedge clk);
    total_cnt++; if (ready !== 1'b0) $display("FAIL mid_wait: ready=%b want 0", ready); else pass_cnt++;
    valid = 1'b0;
    arm;
    send({12'h880, 64'h3C00_3C00_3C00_3C00});
    pulse_done;
    total_cnt++;
    if (nan_num !== 32'd0 || inf_num !== 32'd0)
      $display("FAIL mid_cnt: nan=%0d inf=%0d want 0 0", nan_num, inf_num);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_gating;
    test_flush;
    test_non_fp16;
    test_counts;
    test_backpressure;
`ifdef NVDLA_PDP_NAN_CNT_EN
    test_saturation;
`endif
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
